axis_tensor_loader: RTL and testbench

- AXI4-Stream slave that receives 8-bit tensor bytes for the NPU and converts them into SRAM write commands.
- Receives alternating image and kernel packets. The header fields of each packet are carried on tuser.
- Writes every byte to the selected SRAM bank at a per-packet incrementing address.
- Latches convolution metadata for the GEMM engine and the top-level FSM.

---
 rtl/axis_tensor_loader.sv | 210 +++++++++++++++++++++
 tb/tb_axis_tensor_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tensor_loader.sv
// axis_tensor_loader: AXI4-Stream slave that turns 8-bit tensor bytes into SRAM
// write commands.
//
// Packets strictly alternate between image and kernel. Each packet's header is
// carried on tuser and captured from its first beat.
//
// Optional build macro AXIS_IN_LAST_GAP_EN: when defined, tready drops for one
// cycle after every accepted tlast beat, which inserts an inter-packet gap.
module axis_tensor_loader #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int NUM_CHANNELS_WIDTH = 7,
  parameter int MAX_ADDR_WIDTH     = 16,
  parameter int GEMM0_IDX          = 0,
  parameter int GEMM1_IDX          = 1
) (
  input  logic                                      s_axis_aclk,
  input  logic                                      s_axis_aresetn,
  input  logic signed [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]                   s_axis_tstrb,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic                                      s_axis_tlast,
  input  logic [4*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
  output logic                                      write_enable,
  output logic [MAX_ADDR_WIDTH-1:0]                 write_address,
  output logic signed [DATA_WIDTH-1:0]              write_data,
  output logic [2:0]                                data_type,
  output logic                                      data_ready,
  output logic [ADDR_WIDTH-1:0]                     img_row,
  output logic [ADDR_WIDTH-1:0]                     img_col,
  output logic [ADDR_WIDTH-1:0]                     in_channel,
  output logic [ADDR_WIDTH-1:0]                     batch,
  output logic [ADDR_WIDTH-1:0]                     ker_row,
  output logic [ADDR_WIDTH-1:0]                     ker_col,
  output logic [ADDR_WIDTH-1:0]                     output_channel,
  output logic [3:0]                                stride_h,
  output logic [3:0]                                stride_w,
  output logic                                      padding,
  output logic [NUM_CHANNELS_WIDTH-1:0]             num_channels
);

  localparam logic [2:0]                GEMM0_CODE = 3'(GEMM0_IDX);
  localparam logic [2:0]                GEMM1_CODE = 3'(GEMM1_IDX);
  localparam logic [MAX_ADDR_WIDTH-1:0] CNT_ONE    = MAX_ADDR_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_BODY
  } state_e;

  state_e                        state_q, state_d;
  logic                          pktType_q, pktType_d;
  logic [MAX_ADDR_WIDTH-1:0]     beatCnt_q, beatCnt_d;
  logic                          tready_q, tready_d;
  logic                          dataReady_q, dataReady_d;
  logic                          lastAcc_q;

  logic                          writeEn_q;
  logic [MAX_ADDR_WIDTH-1:0]     writeAddr_q;
  logic signed [DATA_WIDTH-1:0]  writeData_q;

  logic [2:0]                    dataType_q;
  logic [ADDR_WIDTH-1:0]         imgRow_q, imgCol_q, inChannel_q, batch_q;
  logic [ADDR_WIDTH-1:0]         kerRow_q, kerCol_q, outChannel_q;
  logic [3:0]                    strideH_q, strideW_q;
  logic                          padding_q;
  logic [NUM_CHANNELS_WIDTH-1:0] numCh_q;

  logic                          accept;
  logic                          firstBeat;
  logic                          lastBeat;
  logic [ADDR_WIDTH-1:0]         hdrF0, hdrF1, hdrF2, hdrF3;
  logic [NUM_CHANNELS_WIDTH-1:0] hdrNumCh;
  logic [3:0]                    hdrStrideW, hdrStrideH;
  logic [2:0]                    pktCode;

  assign accept    = s_axis_tvalid & tready_q;
  assign firstBeat = accept & (state_q == S_IDLE);
  assign lastBeat  = accept & s_axis_tlast;

  assign hdrF0    = s_axis_tuser[ADDR_WIDTH-1:0];
  assign hdrF1    = s_axis_tuser[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign hdrF2    = s_axis_tuser[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
  assign hdrF3    = s_axis_tuser[4*ADDR_WIDTH-1:3*ADDR_WIDTH];
  assign hdrNumCh = s_axis_tuser[4*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:4*ADDR_WIDTH];

  // A stride of zero is meaningless to the GEMM engine, so it is stored as 1.
  assign hdrStrideW = (hdrF3[3:0] == 4'd0) ? 4'd1 : hdrF3[3:0];
  assign hdrStrideH = (hdrF3[7:4] == 4'd0) ? 4'd1 : hdrF3[7:4];
  assign pktCode    = pktType_q ? GEMM1_CODE : GEMM0_CODE;

  // Next-state logic: packet progress, type toggle, beat counter, load window, ready.
  always_comb begin
    state_d     = state_q;
    pktType_d   = pktType_q;
    beatCnt_d   = beatCnt_q;
    dataReady_d = dataReady_q;
    tready_d    = 1'b1;

    if (lastBeat) begin
      state_d   = S_IDLE;
      pktType_d = ~pktType_q;
      beatCnt_d = '0;
    end else if (accept) begin
      state_d   = S_BODY;
      beatCnt_d = beatCnt_q + CNT_ONE;
    end

    // The window stays open through the tlast write cycle; a new first beat keeps it open.
    if (firstBeat) begin
      dataReady_d = 1'b1;
    end else if (lastAcc_q) begin
      dataReady_d = 1'b0;
    end

`ifdef AXIS_IN_LAST_GAP_EN
    tready_d = ~lastBeat;
`else
    tready_d = 1'b1;
`endif
  end

  // Control state registers.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q     <= S_IDLE;
      pktType_q   <= 1'b0;
      beatCnt_q   <= '0;
      tready_q    <= 1'b0;
      dataReady_q <= 1'b0;
      lastAcc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pktType_q   <= pktType_d;
      beatCnt_q   <= beatCnt_d;
      tready_q    <= tready_d;
      dataReady_q <= dataReady_d;
      lastAcc_q   <= lastBeat;
    end
  end

  // SRAM write port: one cycle behind the accepted beat; a null strobe still uses an address.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      writeEn_q   <= 1'b0;
      writeAddr_q <= '0;
      writeData_q <= '0;
    end else begin
      writeEn_q <= accept & (s_axis_tstrb != '0);
      if (accept) begin
        writeAddr_q <= beatCnt_q;
        writeData_q <= s_axis_tdata;
      end
    end
  end

  // Header capture on the first beat; metadata of the other packet type is untouched.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      dataType_q   <= '0;
      numCh_q      <= '0;
      imgRow_q     <= '0;
      imgCol_q     <= '0;
      inChannel_q  <= '0;
      batch_q      <= '0;
      kerRow_q     <= '0;
      kerCol_q     <= '0;
      outChannel_q <= '0;
      strideH_q    <= 4'd1;
      strideW_q    <= 4'd1;
      padding_q    <= 1'b0;
    end else if (firstBeat) begin
      dataType_q <= pktCode;
      numCh_q    <= hdrNumCh;
      if (!pktType_q) begin
        imgRow_q    <= hdrF0;
        imgCol_q    <= hdrF1;
        inChannel_q <= hdrF2;
        batch_q     <= hdrF3;
      end else begin
        kerRow_q     <= hdrF0;
        kerCol_q     <= hdrF1;
        outChannel_q <= hdrF2;
        strideW_q    <= hdrStrideW;
        strideH_q    <= hdrStrideH;
        padding_q    <= hdrF3[8];
      end
    end
  end

  assign s_axis_tready  = tready_q;
  assign write_enable   = writeEn_q;
  assign write_address  = writeAddr_q;
  assign write_data     = writeData_q;
  assign data_type      = dataType_q;
  assign data_ready     = dataReady_q;
  assign img_row        = imgRow_q;
  assign img_col        = imgCol_q;
  assign in_channel     = inChannel_q;
  assign batch          = batch_q;
  assign ker_row        = kerRow_q;
  assign ker_col        = kerCol_q;
  assign output_channel = outChannel_q;
  assign stride_h       = strideH_q;
  assign stride_w       = strideW_q;
  assign padding        = padding_q;
  assign num_channels   = numCh_q;

endmodule

// File: tb/tb_axis_tensor_loader.sv
// tb_axis_tensor_loader: directed, self-checking bench for axis_tensor_loader.
//
// Expected SRAM writes go into a scoreboard queue when a beat is accepted. They
// are popped and compared when write_enable is seen one cycle later. The
// AXIS_IN_LAST_GAP_EN macro selects the expected tready behaviour.
module tb_axis_tensor_loader;

  localparam int AW  = 13;
  localparam int NCW = 7;
  localparam int TUW = 4*AW+NCW;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic            clk;
  logic            rst_n;
  logic [7:0]      s_axis_tdata;
  logic [0:0]      s_axis_tstrb;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [TUW-1:0]  s_axis_tuser;
  logic            write_enable;
  logic [15:0]     write_address;
  logic [7:0]      write_data;
  logic [2:0]      data_type;
  logic            data_ready;
  logic [AW-1:0]   img_row, img_col, in_channel, batch;
  logic [AW-1:0]   ker_row, ker_col, output_channel;
  logic [3:0]      stride_h, stride_w;
  logic            padding;
  logic [NCW-1:0]  num_channels;

  wr_t         sbQ[$];
  logic [15:0] expAddr;
  logic        expReady;
  logic        expWe;
  int          drCycles;
  int          assertCount;
  int          failCount;

  axis_tensor_loader dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .data_type      (data_type),
    .data_ready     (data_ready),
    .img_row        (img_row),
    .img_col        (img_col),
    .in_channel     (in_channel),
    .batch          (batch),
    .ker_row        (ker_row),
    .ker_col        (ker_col),
    .output_channel (output_channel),
    .stride_h       (stride_h),
    .stride_w       (stride_w),
    .padding        (padding),
    .num_channels   (num_channels)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [TUW-1:0] mkUser(input logic [AW-1:0] f0, input logic [AW-1:0] f1,
                                            input logic [AW-1:0] f2, input logic [AW-1:0] f3,
                                            input logic [NCW-1:0] nc);
    return {nc, f3, f2, f1, f0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock from a negedge to the next negedge, updating the model and checking the write port.
  task automatic stepCycle();
    logic acc;
    logic lastAcc;
    wr_t  exp;
    acc     = s_axis_tvalid && expReady;
    lastAcc = acc && s_axis_tlast;
    if (acc && (s_axis_tstrb != 1'b0)) sbQ.push_back('{addr: expAddr, data: s_axis_tdata});
    expWe = acc && (s_axis_tstrb != 1'b0);
    if (acc) expAddr = lastAcc ? 16'd0 : expAddr + 16'd1;
    @(posedge clk);
`ifdef AXIS_IN_LAST_GAP_EN
    expReady = !lastAcc;
`else
    expReady = 1'b1;
`endif
    @(negedge clk);
    if (data_ready === 1'b1) drCycles++;
    checkOutput("tready", s_axis_tready, expReady);
    checkOutput("write_enable", write_enable, expWe);
    if (write_enable === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_depth_on_write", sbQ.size(), 1);
      end else begin
        exp = sbQ.pop_front();
        checkOutput("write_address", write_address, exp.addr);
        checkOutput("write_data", write_data, exp.data);
      end
    end
  endtask

  // Present one beat and hold it until the model says it is accepted.
  task automatic applyStimulus(input logic [7:0] d, input logic strb, input logic last, input logic [TUW-1:0] user);
    int guard;
    s_axis_tdata  = d;
    s_axis_tstrb  = strb;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    guard = 0;
    while (!expReady && guard < 8) begin
      stepCycle();
      guard++;
    end
    if (guard >= 8) checkOutput("accept_wait", guard, 0);
    stepCycle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic sendPacket(input int n, input logic [7:0] base, input logic [TUW-1:0] user, input bit withLast);
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + 8'(i), 1'b1, withLast && (i == n-1), (i == 0) ? user : ~user);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic checkResetState();
    checkOutput("rst_tready", s_axis_tready, 0);
    checkOutput("rst_write_enable", write_enable, 0);
    checkOutput("rst_write_address", write_address, 0);
    checkOutput("rst_write_data", write_data, 0);
    checkOutput("rst_data_type", data_type, 0);
    checkOutput("rst_data_ready", data_ready, 0);
    checkOutput("rst_img_row", img_row, 0);
    checkOutput("rst_batch", batch, 0);
    checkOutput("rst_ker_col", ker_col, 0);
    checkOutput("rst_stride_h", stride_h, 1);
    checkOutput("rst_stride_w", stride_w, 1);
    checkOutput("rst_padding", padding, 0);
    checkOutput("rst_num_channels", num_channels, 0);
  endtask

  // Assert reset asynchronously in mid-cycle, check the cleared state, then release.
  task automatic applyReset();
    #2;
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    sbQ.delete();
    expAddr  = '0;
    expReady = 1'b0;
    expWe    = 1'b0;
    #1;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
  endtask

  // Directed test sequence.
  initial begin
    clk           = 1'b0;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    expAddr       = '0;
    expReady      = 1'b0;
    expWe         = 1'b0;
    drCycles      = 0;
    assertCount   = 0;
    failCount     = 0;

    repeat (2) @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    idle(2);
    checkOutput("idle_data_ready", data_ready, 0);

    $display("[TB] image packet, 16 beats");
    drCycles = 0;
    sendPacket(16, 8'd0, mkUser(13'd4, 13'd4, 13'd1, 13'd1, 7'd1), 1'b1);
    checkOutput("img_data_type", data_type, 0);
    idle(2);
    checkOutput("img_data_ready_cycles", drCycles, 16);
    checkOutput("img_row", img_row, 4);
    checkOutput("img_col", img_col, 4);
    checkOutput("img_in_channel", in_channel, 1);
    checkOutput("img_batch", batch, 1);
    checkOutput("img_num_channels", num_channels, 1);
    checkOutput("img_ker_row_kept", ker_row, 0);
    checkOutput("img_data_ready_low", data_ready, 0);

    $display("[TB] kernel packet, 4 beats");
    sendPacket(4, 8'hF0, mkUser(13'd2, 13'd2, 13'd1, 13'h011, 7'd3), 1'b1);
    idle(1);
    checkOutput("ker_data_type", data_type, 1);
    checkOutput("ker_row", ker_row, 2);
    checkOutput("ker_col", ker_col, 2);
    checkOutput("ker_output_channel", output_channel, 1);
    checkOutput("ker_stride_h", stride_h, 1);
    checkOutput("ker_stride_w", stride_w, 1);
    checkOutput("ker_padding", padding, 0);
    checkOutput("ker_num_channels", num_channels, 3);
    checkOutput("ker_img_row_kept", img_row, 4);
    checkOutput("ker_batch_kept", batch, 1);

    $display("[TB] single-beat image, strided kernels");
    drCycles = 0;
    sendPacket(1, 8'h5A, mkUser(13'd7, 13'd5, 13'd3, 13'd2, 7'd4), 1'b1);
    idle(2);
    checkOutput("img1_data_ready_cycles", drCycles, 1);
    checkOutput("img1_data_type", data_type, 0);
    checkOutput("img1_img_row", img_row, 7);
    checkOutput("img1_in_channel", in_channel, 3);
    checkOutput("img1_ker_row_kept", ker_row, 2);
    sendPacket(2, 8'h80, mkUser(13'd3, 13'd3, 13'd2, 13'h153, 7'd2), 1'b1);
    idle(1);
    checkOutput("ker2_stride_h", stride_h, 5);
    checkOutput("ker2_stride_w", stride_w, 3);
    checkOutput("ker2_padding", padding, 1);
    checkOutput("ker2_ker_row", ker_row, 3);
    sendPacket(1, 8'h11, mkUser(13'd8, 13'd8, 13'd2, 13'd1, 7'd2), 1'b1);
    sendPacket(2, 8'h20, mkUser(13'd1, 13'd1, 13'd1, 13'h100, 7'd2), 1'b1);
    idle(1);
    checkOutput("ker3_data_type", data_type, 1);
    checkOutput("ker3_stride_h", stride_h, 1);
    checkOutput("ker3_stride_w", stride_w, 1);
    checkOutput("ker3_padding", padding, 1);

    $display("[TB] null strobe and tvalid gaps");
    applyStimulus(8'd11, 1'b1, 1'b0, mkUser(13'd3, 13'd1, 13'd1, 13'd1, 7'd1));
    checkOutput("gap_data_type", data_type, 0);
    idle(2);
    applyStimulus(8'd22, 1'b0, 1'b0, '0);
    idle(3);
    applyStimulus(8'd33, 1'b1, 1'b1, '0);
    idle(1);
    checkOutput("gap_img_row", img_row, 3);

    $display("[TB] back-to-back packets");
    drCycles = 0;
    sendPacket(2, 8'h40, mkUser(13'd5, 13'd5, 13'd5, 13'h022, 7'd5), 1'b1);
    sendPacket(2, 8'h50, mkUser(13'd6, 13'd6, 13'd6, 13'd6, 7'd6), 1'b1);
    idle(2);
    checkOutput("b2b_data_ready_cycles", drCycles, 4);
    checkOutput("b2b_data_type", data_type, 0);
    checkOutput("b2b_stride_h", stride_h, 2);
    checkOutput("b2b_img_row", img_row, 6);

    $display("[TB] reset in the middle of packets");
    sendPacket(1, 8'h60, mkUser(13'd1, 13'd1, 13'd1, 13'd1, 7'd1), 1'b1);
    sendPacket(5, 8'h70, mkUser(13'd9, 13'd9, 13'd9, 13'd9, 7'd9), 1'b0);
    applyReset();
    sendPacket(3, 8'hA0, mkUser(13'd2, 13'd3, 13'd4, 13'd5, 7'd6), 1'b1);
    checkOutput("post_rst_data_type", data_type, 0);
    checkOutput("post_rst_img_col", img_col, 3);
    sendPacket(1, 8'hB0, mkUser(13'd4, 13'd4, 13'd4, 13'd4, 7'd4), 1'b0);
    checkOutput("mid_ker_data_type", data_type, 1);
    applyReset();
    sendPacket(1, 8'hC0, mkUser(13'd1, 13'd2, 13'd3, 13'd4, 7'd5), 1'b1);
    checkOutput("toggle_reset_data_type", data_type, 0);
    checkOutput("toggle_reset_ker_row", ker_row, 0);
    idle(2);

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
